spi_slave_fsm: RTL

Sequencing controller for the SPI-slave memory datapath.
- Watches the conditioned chip-select and the one-clk-wide serial-clock rising-edge pulse.
- Counts address and data bits.
- Drives the control strobes for the 8-bit shift register, address latch, data memory and MISO tri-state buffer.
- Transaction format, MSB first: ADDR_BITS address bits, one R/W bit (1 = read, 0 = write), then DATA_BITS data bits, shifted out (read) or in (write).

---
 rtl/spi_slave_fsm_pkg.sv | 49 ++++
 rtl/spi_slave_fsm_bit_counter.sv | 40 ++++
 rtl/spi_slave_fsm.sv | 98 +++++++++
 3 files changed

// File: rtl/spi_slave_fsm_pkg.sv
// Shared types and constants for the SPI-slave sequencing controller.
// Holds the state encoding and the per-state control-strobe decode.
package spi_pkg;

  localparam int ADDR_BITS_DEF = 7;
  localparam int DATA_BITS_DEF = 8;
  localparam int CNT_W_DEF     = 4;

  // Value of the R/W bit that selects a read transaction.
  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_ADDR    = 3'd1,
    GOT_ADDR    = 3'd2,
    READ_LOAD   = 3'd3,
    READ_SHIFT  = 3'd4,
    WRITE_SHIFT = 3'd5,
    WRITE_MEM   = 3'd6,
    DONE        = 3'd7
  } state_e;

  typedef struct packed {
    logic addr_we;
    logic sr_we;
    logic dm_we;
    logic miso_bufe;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '{default: 1'b0};

  // Moore decode: every strobe is a pure function of the state, so at most
  // one of addr_we / sr_we / dm_we can ever be high.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c      = CTRL_OFF;
    c.busy = (s != IDLE);
    case (s)
      GOT_ADDR:   c.addr_we   = 1'b1;
      READ_LOAD:  c.sr_we     = 1'b1;
      READ_SHIFT: c.miso_bufe = 1'b1;
      WRITE_MEM:  c.dm_we     = 1'b1;
      default:    ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spi_slave_fsm_bit_counter.sv
// Bit counter for the address and data phases: synchronous clear, increment
// enable, and a flag marking the increment that reaches the terminal count.
module spi_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // High on the clk that samples the term-th edge; the owner leaves the state
  // on that clk, so the counter never wraps.
  assign last = inc && (count_q == term - CNT_W'(1));

endmodule

// File: rtl/spi_slave_fsm.sv
// Sequencing controller for the SPI-slave memory datapath: counts address and
// data bits and drives the shift-register, address-latch, memory and MISO strobes.
module spi_slave_fsm
  import spi_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic resetN,
  input  logic csConditioned,
  input  logic sclkPosEdge,
  input  logic shiftRegOutP0,
  output logic addrWe,
  output logic srWe,
  output logic dmWe,
  output logic misoBufe,
  output logic busy
);

  state_e           state_q;
  state_e           state_d;
  ctrl_t            ctrl_q;
  ctrl_t            ctrl_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_term;
  logic             counting;
  logic             cs_release;

  assign cs_release = csConditioned;
  assign counting   = (state_q == GET_ADDR) || (state_q == READ_SHIFT) ||
                      (state_q == WRITE_SHIFT);

  // A CS release in the same clk as an edge must not advance the count.
  assign cnt_inc  = counting && sclkPosEdge && !cs_release;
  assign cnt_term = (state_q == GET_ADDR) ? CNT_W'(ADDR_BITS + 1)
                                          : CNT_W'(DATA_BITS);
  assign cnt_clr  = (state_d != state_q) || (state_q == IDLE);

  spi_bit_counter #(
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk   (clk),
    .rst_n (resetN),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .term  (cnt_term),
    .last  (cnt_last)
  );

  // NOTE: state_d is assigned a default before the case so no path through
  // this block leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (!csConditioned) begin
        state_d = GET_ADDR;
      end
    end else if (cs_release) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        GET_ADDR:    if (cnt_last) state_d = GOT_ADDR;
        GOT_ADDR:    state_d = (shiftRegOutP0 == RW_READ) ? READ_LOAD : WRITE_SHIFT;
        READ_LOAD:   state_d = READ_SHIFT;
        READ_SHIFT:  if (cnt_last) state_d = DONE;
        WRITE_SHIFT: if (cnt_last) state_d = WRITE_MEM;
        WRITE_MEM:   state_d = DONE;
        DONE:        state_d = DONE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Strobes are decoded from the next state and registered, so each output
  // is a flop that mirrors the registered state without decode glitches.
  assign ctrl_d = decode_ctrl(state_d);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ctrl_q  <= CTRL_OFF;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign addrWe   = ctrl_q.addr_we;
  assign srWe     = ctrl_q.sr_we;
  assign dmWe     = ctrl_q.dm_we;
  assign misoBufe = ctrl_q.miso_bufe;
  assign busy     = ctrl_q.busy;

endmodule
